// File: rtl/bcd_digit_converter.sv
// ============================================================================
// Module      : bcd_digit_converter
// Description : Iterative double-dabble binary-to-BCD converter that commits
//               eight display digits atomically with optional zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_converter #(
  parameter int BIN_W    = 27,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [3:0]       o_dig0,
  output logic [3:0]       o_dig1,
  output logic [3:0]       o_dig2,
  output logic [3:0]       o_dig3,
  output logic [3:0]       o_dig4,
  output logic [3:0]       o_dig5,
  output logic [3:0]       o_dig6,
  output logic [3:0]       o_dig7
);

  localparam logic [4:0] c_LAST   = 5'(BIN_W - 1);
  localparam logic [3:0] c_RST_HI = BLANK_LZ ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [BIN_W-1:0]   r_shift;
  logic [31:0]        r_acc;
  logic [4:0]         r_cnt;
  logic               r_ovf_flag;
  logic               r_done;
  logic               r_overflow;
  logic [31:0]        r_dig;

  logic               w_sat;
  logic [BIN_W-1:0]   w_bin_cap;
  logic [31:0]        w_adj;
  logic [7:1]         w_lead;
  logic [31:0]        w_dig;

  // Only a full 27-bit input can exceed eight decimal digits.
  generate
    if (BIN_W >= 27) begin : g_sat
      localparam logic [BIN_W-1:0] c_MAX = BIN_W'(99_999_999);
      assign w_sat     = (i_bin > c_MAX);
      assign w_bin_cap = w_sat ? c_MAX : i_bin;
    end else begin : g_nosat
      assign w_sat     = 1'b0;
      assign w_bin_cap = i_bin;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CONV;
      S_CONV:  if (r_cnt == c_LAST) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 8; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  // w_lead[i] is set when digit i and every digit above it are zero.
  always_comb begin
    w_lead    = '0;
    w_lead[7] = (r_acc[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--) begin
      w_lead[i] = w_lead[i+1] && (r_acc[i*4 +: 4] == 4'd0);
    end
    w_dig = r_acc;
    for (int i = 1; i < 8; i++) begin
      if (BLANK_LZ && w_lead[i]) begin
        w_dig[i*4 +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_dig      <= {{7{c_RST_HI}}, 4'h0};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shift    <= w_bin_cap;
            r_ovf_flag <= w_sat;
            r_acc      <= '0;
            r_cnt      <= '0;
          end
        end
        S_CONV: begin
          {r_acc, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt            <= r_cnt + 5'd1;
        end
        S_FIN: begin
          r_dig      <= w_dig;
          r_overflow <= r_ovf_flag;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_dig0     = r_dig[3:0];
  assign o_dig1     = r_dig[7:4];
  assign o_dig2     = r_dig[11:8];
  assign o_dig3     = r_dig[15:12];
  assign o_dig4     = r_dig[19:16];
  assign o_dig5     = r_dig[23:20];
  assign o_dig6     = r_dig[27:24];
  assign o_dig7     = r_dig[31:28];

endmodule

`default_nettype wire

// File: tb/tb_bcd_digit_converter.sv
// ============================================================================
// Module      : tb_bcd_digit_converter
// Description : Scoreboard bench for bcd_digit_converter, blanking on and off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_digit_converter;

  localparam int BIN_W = 27;

  typedef struct {
    logic [31:0] db;
    logic [31:0] dn;
    logic        ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin;

  logic       b_busy, b_done, b_ovf;
  logic [3:0] b0, b1, b2, b3, b4, b5, b6, b7;
  logic       n_busy, n_done, n_ovf;
  logic [3:0] n0, n1, n2, n3, n4, n5, n6, n7;

  logic [31:0] dig_b;
  logic [31:0] dig_n;
  assign dig_b = {b7, b6, b5, b4, b3, b2, b1, b0};
  assign dig_n = {n7, n6, n5, n4, n3, n2, n1, n0};

  exp_t sb[$];
  int   nchk  = 0;
  int   nfail = 0;
  int   cyc   = 0;
  int   t0    = 0;

  bcd_digit_converter #(.BIN_W(BIN_W), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_bin(bin),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf),
    .o_dig0(b0), .o_dig1(b1), .o_dig2(b2), .o_dig3(b3),
    .o_dig4(b4), .o_dig5(b5), .o_dig6(b6), .o_dig7(b7)
  );

  bcd_digit_converter #(.BIN_W(BIN_W), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_bin(bin),
    .o_busy(n_busy), .o_done(n_done), .o_overflow(n_ovf),
    .o_dig0(n0), .o_dig1(n1), .o_dig2(n2), .o_dig3(n3),
    .o_dig4(n4), .o_dig5(n5), .o_dig6(n6), .o_dig7(n7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input longint v, input bit blank);
    longint      x;
    logic [31:0] d;
    int          top;
    x   = (v > 64'd99999999) ? 64'd99999999 : v;
    d   = '0;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      d[i*4 +: 4] = 4'(x % 10);
      if ((x % 10) != 0) top = i;
      x = x / 10;
    end
    if (blank) begin
      for (int i = 1; i < 8; i++) begin
        if (i > top) d[i*4 +: 4] = 4'hF;
      end
    end
    return d;
  endfunction

  // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic start_conv(input longint v);
    exp_t e;
    e.db  = model(v, 1'b1);
    e.dn  = model(v, 1'b0);
    e.ovf = (v > 64'd99999999);
    sb.push_back(e);
    start = 1'b1;
    bin   = BIN_W'(v);
    @(posedge clk); #1;
    t0    = cyc;
    start = 1'b0;
    bin   = BIN_W'($urandom);
    nchk++;
    if (b_busy !== 1'b1 || n_busy !== 1'b1) begin
      nfail++;
      $display("FAIL busy_after_start: got %b/%b, want 1/1", b_busy, n_busy);
    end
  endtask

  // Waits for done, then checks latency, holding, busy and scoreboard digits.
  task automatic wait_result(input string tag);
    exp_t        e;
    logic [31:0] hb, hn;
    bit          held, busy_ok, got;
    int          lat;
    hb = dig_b; hn = dig_n; held = 1; busy_ok = 1; got = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (b_done === 1'b1) begin
        got = 1;
        break;
      end
      if (dig_b !== hb || dig_n !== hn) held = 0;
      if (b_busy !== 1'b1) busy_ok = 0;
    end
    nchk++;
    if (!got) begin
      nfail++;
      $display("FAIL %s timeout: done not seen in 60 cycles, want done", tag);
      return;
    end
    lat = cyc - t0;
    nchk++;
    if (lat != BIN_W + 1) begin
      nfail++;
      $display("FAIL %s latency: got %0d, want %0d", tag, lat, BIN_W + 1);
    end
    nchk++;
    if (!held || !busy_ok || b_busy !== 1'b0 || n_done !== 1'b1) begin
      nfail++;
      $display("FAIL %s hold/busy: held=%b busy_ok=%b busy=%b nb_done=%b, want 1 1 0 1",
               tag, held, busy_ok, b_busy, n_done);
    end
    nchk++;
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL %s scoreboard: got done, want no pending result", tag);
      return;
    end
    e = sb.pop_front();
    nchk++;
    if (dig_b !== e.db) begin
      nfail++;
      $display("FAIL %s digits_blank: got %h, want %h", tag, dig_b, e.db);
    end
    nchk++;
    if (dig_n !== e.dn) begin
      nfail++;
      $display("FAIL %s digits_noblank: got %h, want %h", tag, dig_n, e.dn);
    end
    nchk++;
    if (b_ovf !== e.ovf || n_ovf !== e.ovf) begin
      nfail++;
      $display("FAIL %s overflow: got %b/%b, want %b", tag, b_ovf, n_ovf, e.ovf);
    end
  endtask

  task automatic check_reset_values(input string tag);
    nchk++;
    if (b_busy !== 1'b0 || b_done !== 1'b0 || b_ovf !== 1'b0 ||
        n_busy !== 1'b0 || n_done !== 1'b0 || n_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL %s ctrl: busy=%b done=%b ovf=%b nb=%b%b%b, want all 0",
               tag, b_busy, b_done, b_ovf, n_busy, n_done, n_ovf);
    end
    nchk++;
    if (dig_b !== 32'hFFFF_FFF0) begin
      nfail++;
      $display("FAIL %s digits_blank: got %h, want ffffff f0", tag, dig_b);
    end
    nchk++;
    if (dig_n !== 32'h0000_0000) begin
      nfail++;
      $display("FAIL %s digits_noblank: got %h, want 00000000", tag, dig_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    start_conv(0);
    wait_result("zero");
    @(posedge clk); #1;
    nchk++;
    if (b_done !== 1'b0) begin
      nfail++;
      $display("FAIL done_width: got %b one cycle later, want 0", b_done);
    end
  endtask

  task automatic test_basic();
    start_conv(12345678);
    wait_result("basic");
    @(posedge clk); #1;
    start_conv(1000);
    wait_result("inner_zeros");
  endtask

  task automatic test_saturation();
    start_conv(99999999);
    wait_result("max_legal");
    start_conv(134217727);
    wait_result("saturate");
    start_conv(405);
    wait_result("after_sat");
    nchk++;
    if (dig_n !== 32'h0000_0405 || dig_b !== 32'hFFFF_F405) begin
      nfail++;
      $display("FAIL digits_405: got %h/%h, want fffff405/00000405", dig_b, dig_n);
    end
  endtask

  task automatic test_ignore_start();
    bit stray;
    start_conv(4321);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    bin   = BIN_W'(8765);
    @(posedge clk); #1;
    start = 1'b0;
    wait_result("ignore_start");
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b_done !== 1'b0 || b_busy !== 1'b0) stray = 1;
    end
    nchk++;
    if (stray || sb.size() != 0) begin
      nfail++;
      $display("FAIL ignore_single_done: stray=%b pending=%0d, want 0 0", stray, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    start_conv(111);
    wait_result("b2b_first");
    start_conv(87654321);
    nchk++;
    if (b_done !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_done_low: got %b, want 0", b_done);
    end
    wait_result("b2b_second");
  endtask

  task automatic test_reset_abort();
    bit stray;
    @(posedge clk); #1;
    start_conv(134217727);
    wait_result("pre_abort");
    @(posedge clk); #1;
    start_conv(55555);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    void'(sb.pop_back());
    stray = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b_done !== 1'b0) stray = 1;
    end
    rst_n = 1'b1;
    repeat (35) begin
      @(posedge clk); #1;
      if (b_done !== 1'b0 || b_busy !== 1'b0) stray = 1;
    end
    nchk++;
    if (stray) begin
      nfail++;
      $display("FAIL abort_no_done: got done/busy activity, want none");
    end
    start_conv(7);
    wait_result("after_abort");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_saturation();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
